// File: rtl/copper_bus_arb.sv
// copper_bus_arb: shares one bus master port between NREQ requesters.
// Requester 0 (the copper master) can optionally get fixed priority. All
// other requesters are served round-robin. A strobe that waits too long
// for an ack is ended with an err pulse and a FLUSH state.
// Ports:
//   clk_i, rst_i                 clock and synchronous active-low reset
//   cyc_i/stb_i/we_i/sel_i/      per-requester bus requests (packed by index)
//   adr_i/dat_i
//   ack_o, err_o, dat_o          per-requester ack and timeout error, plus
//                                broadcast read data
//   mcyc_o..mdat_o               shared master port driven from the owner
//   mack_i, mdat_i               slave response
//   grant_o                      one-hot owner, or zero when idle
module copper_bus_arb #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned PRI0    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      cyc_i,
  input  logic [NREQ-1:0]      stb_i,
  input  logic [NREQ-1:0]      we_i,
  input  logic [4*NREQ-1:0]    sel_i,
  input  logic [32*NREQ-1:0]   adr_i,
  input  logic [32*NREQ-1:0]   dat_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [NREQ-1:0]      err_o,
  output logic [31:0]          dat_o,
  output logic                 mcyc_o,
  output logic                 mstb_o,
  output logic                 mwe_o,
  output logic [3:0]           msel_o,
  output logic [31:0]          madr_o,
  output logic [31:0]          mdat_o,
  input  logic                 mack_i,
  input  logic [31:0]          mdat_i,
  output logic [NREQ-1:0]      grant_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  state_t          state;
  logic [IW-1:0]   last_owner;
  logic [CW-1:0]   cnt;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;

  logic            busy;
  logic            own_cyc;
  logic            own_stb;
  logic            own_we;
  logic [3:0]      own_sel;
  logic [31:0]     own_adr;
  logic [31:0]     own_dat;

  // Winner selection. Scan downward so the closest index after last_owner
  // is written last and wins. last_owner is the lowest priority.
  always_comb begin
    win_vld = |cyc_i;
    win_idx = '0;
    cand    = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      cand = IW'((int'(last_owner) + k) % int'(NREQ));
      if (cyc_i[cand]) win_idx = cand;
    end
    if (PRI0 != 0 && cyc_i[0]) win_idx = '0;
  end

  // The owner index is last_owner while a grant is held.
  assign own_cyc = cyc_i[last_owner];
  assign own_stb = stb_i[last_owner];
  assign own_we  = we_i[last_owner];
  assign own_sel = sel_i[int'(last_owner)*4 +: 4];
  assign own_adr = adr_i[int'(last_owner)*32 +: 32];
  assign own_dat = dat_i[int'(last_owner)*32 +: 32];

  assign busy   = (state == BUSY);
  assign mcyc_o = busy & own_cyc;
  assign mstb_o = busy & own_stb;
  assign mwe_o  = busy & own_we;
  assign msel_o = busy ? own_sel : 4'h0;
  assign madr_o = busy ? own_adr : 32'h0;
  assign mdat_o = busy ? own_dat : 32'h0;
  assign dat_o  = mdat_i;

  // Ack is steered to the owner only.
  always_comb begin
    ack_o             = '0;
    ack_o[last_owner] = mack_i & mstb_o;
  end

  // State, grant, round-robin pointer and timeout counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      grant_o    <= '0;
      last_owner <= IW'(NREQ - 1);
      cnt        <= '0;
      err_o      <= '0;
    end else begin
      err_o <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (win_vld) begin
            grant_o    <= NREQ'(1) << win_idx;
            last_owner <= win_idx;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (!own_cyc) begin
            // The owner is released, and the next owner is chosen on the same edge.
            cnt <= '0;
            if (win_vld) begin
              grant_o    <= NREQ'(1) << win_idx;
              last_owner <= win_idx;
            end else begin
              grant_o <= '0;
              state   <= IDLE;
            end
          end else if (mstb_o && !mack_i) begin
            if (cnt == TO_LAST) begin
              err_o[last_owner] <= 1'b1;
              cnt               <= '0;
              state             <= FLUSH;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        FLUSH: begin
          cnt <= '0;
          if (!own_cyc) begin
            grant_o <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          grant_o <= '0;
          cnt     <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_copper_bus_arb.sv
// Randomized bench for copper_bus_arb. It drives two instances from the same
// inputs: one with fixed priority for requester 0 and one pure round-robin,
// both with TIMEOUT=4. A transaction-level model predicts every output.
module tb_copper_bus_arb;

  localparam int N  = 3;
  localparam int TO = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      cyc_i, stb_i, we_i;
  logic [4*N-1:0]    sel_i;
  logic [32*N-1:0]   adr_i, dat_i;
  logic              mack_i;
  logic [31:0]       mdat_i;

  logic [N-1:0]      ack_o   [2];
  logic [N-1:0]      err_o   [2];
  logic [N-1:0]      grant_o [2];
  logic [31:0]       dat_o   [2];
  logic [31:0]       madr_o  [2];
  logic [31:0]       mdat_o  [2];
  logic [3:0]        msel_o  [2];
  logic              mcyc_o  [2];
  logic              mstb_o  [2];
  logic              mwe_o   [2];

  always #5 clk_i = ~clk_i;

  copper_bus_arb #(.NREQ(N), .TIMEOUT(TO), .PRI0(1)) u_pri (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o[0]), .err_o(err_o[0]),
    .dat_o(dat_o[0]), .mcyc_o(mcyc_o[0]), .mstb_o(mstb_o[0]), .mwe_o(mwe_o[0]),
    .msel_o(msel_o[0]), .madr_o(madr_o[0]), .mdat_o(mdat_o[0]), .mack_i(mack_i),
    .mdat_i(mdat_i), .grant_o(grant_o[0])
  );

  copper_bus_arb #(.NREQ(N), .TIMEOUT(TO), .PRI0(0)) u_rr (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o[1]), .err_o(err_o[1]),
    .dat_o(dat_o[1]), .mcyc_o(mcyc_o[1]), .mstb_o(mstb_o[1]), .mwe_o(mwe_o[1]),
    .msel_o(msel_o[1]), .madr_o(madr_o[1]), .mdat_o(mdat_o[1]), .mack_i(mack_i),
    .mdat_i(mdat_i), .grant_o(grant_o[1])
  );

  // Model state per instance: 0=idle 1=busy 2=flush, owner, stall count, err.
  int           m_st  [2];
  int           m_own [2];
  int           m_cnt [2];
  logic [N-1:0] m_err [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Fixed priority for requester 0 when enabled. Otherwise, scan upward from last owner + 1.
  function automatic int pick(input int i);
    if (i == 0 && cyc_i[0]) return 0;
    for (int s = 1; s <= N; s++) begin
      int j;
      j = (m_own[i] + s) % N;
      if (cyc_i[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit          busy;
      int          o;
      logic [70:0] em, gm;
      logic [N-1:0] eack, egnt;
      busy = (m_st[i] == 1);
      o    = m_own[i];
      em   = busy ? {cyc_i[o], stb_i[o], we_i[o], sel_i[o*4 +: 4],
                     adr_i[o*32 +: 32], dat_i[o*32 +: 32]} : 71'h0;
      gm   = {mcyc_o[i], mstb_o[i], mwe_o[i], msel_o[i], madr_o[i], mdat_o[i]};
      eack = (busy && stb_i[o] && mack_i) ? N'(1 << o) : '0;
      egnt = (m_st[i] == 0) ? '0 : N'(1 << o);
      chk($sformatf("grant%0d", i),  128'(grant_o[i]), 128'(egnt));
      chk($sformatf("ack%0d", i),    128'(ack_o[i]),   128'(eack));
      chk($sformatf("err%0d", i),    128'(err_o[i]),   128'(m_err[i]));
      chk($sformatf("master%0d", i), 128'(gm),         128'(em));
      chk($sformatf("dat%0d", i),    128'(dat_o[i]),   128'(mdat_i));
    end
  endtask

  // Apply one clock edge of the arbitration and timeout rules to the model.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int w;
      m_err[i] = '0;
      if (!rst_i) begin
        m_st[i] = 0; m_own[i] = N - 1; m_cnt[i] = 0;
      end else begin
        case (m_st[i])
          0: begin
            m_cnt[i] = 0;
            w = pick(i);
            if (w >= 0) begin m_own[i] = w; m_st[i] = 1; end
          end
          1: begin
            if (!cyc_i[m_own[i]]) begin
              m_cnt[i] = 0;
              w = pick(i);
              if (w >= 0) m_own[i] = w;
              else m_st[i] = 0;
            end else if (stb_i[m_own[i]] && !mack_i) begin
              if (m_cnt[i] == TO - 1) begin
                m_err[i][m_own[i]] = 1'b1; m_st[i] = 2; m_cnt[i] = 0;
              end else begin
                m_cnt[i]++;
              end
            end else begin
              m_cnt[i] = 0;
            end
          end
          default: if (!cyc_i[m_own[i]]) m_st[i] = 0;
        endcase
      end
    end
  endtask

  // Inputs are already driven at the negedge. Check, then advance through the next edge.
  task automatic step_cycle();
    #1;
    check_all();
    model_step();
    @(negedge clk_i);
  endtask

  initial begin
    int pct [4];
    pct[0] = 50; pct[1] = 0; pct[2] = 15; pct[3] = 30;
    rst_i = 1'b0; cyc_i = '0; stb_i = '0; we_i = '0; sel_i = '0;
    adr_i = '0; dat_i = '0; mack_i = 1'b0; mdat_i = '0;
    @(negedge clk_i);
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_own[i] = N - 1; m_cnt[i] = 0; m_err[i] = '0;
    end
    step_cycle();

    // Single request from requester 1, then an ack.
    rst_i = 1'b1;
    cyc_i = 3'b010; stb_i = 3'b010; adr_i[32 +: 32] = 32'h1000;
    step_cycle();
    mack_i = 1'b1; mdat_i = 32'hCAFE_0001;
    step_cycle();
    mack_i = 1'b0; cyc_i = '0; stb_i = '0;
    step_cycle();

    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        for (int r = 0; r < N; r++)
          if ($urandom_range(5) == 0) cyc_i[r] = ~cyc_i[r];
        stb_i  = N'($urandom) | N'($urandom);
        we_i   = N'($urandom);
        sel_i  = (4*N)'($urandom);
        for (int r = 0; r < N; r++) begin
          adr_i[r*32 +: 32] = $urandom;
          dat_i[r*32 +: 32] = $urandom;
        end
        mdat_i = $urandom;
        mack_i = ($urandom_range(99) < pct[ph]);
        rst_i  = ($urandom_range(99) != 0);
        step_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/copper_bus_arb.md
COPPER_BUS_ARB -- requirements
Module: copper_bus_arb

Interface
REQ-001 Parameter NREQ, default 3: number of bus requesters; requester 0 is the copper master port.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles a strobe may wait for an ack, 8-bit range 1..255.
REQ-003 Parameter PRI0, default 1: when 1, requester 0 has fixed priority over the round-robin group.
REQ-004 clk_i  in  1  single clock for all logic.
REQ-005 rst_i  in  1  reset, synchronous, active-low.
REQ-006 cyc_i, stb_i, we_i  in  NREQ each  per-requester bus cycle, strobe and write enable.
REQ-007 sel_i  in  4*NREQ  per-requester byte selects.
REQ-008 adr_i, dat_i  in  32*NREQ  per-requester address and write data.
REQ-009 ack_o, err_o  out  NREQ each  per-requester acknowledge and timeout-error pulse.
REQ-010 dat_o  out  32  read data, broadcast to all requesters.
REQ-011 mcyc_o, mstb_o, mwe_o  out  1 each  shared master cycle, strobe and write enable.
REQ-012 msel_o  out  4  shared master byte selects.
REQ-013 madr_o, mdat_o  out  32 each  shared master address and write data.
REQ-014 mack_i  in  1  slave acknowledge.
REQ-015 mdat_i  in  32  slave read data.
REQ-016 grant_o  out  NREQ  one-hot owner indication, all-zero when idle.

Function
REQ-017 States SHALL be IDLE, BUSY and FLUSH; the state and grant register update only on a rising clk_i edge.
REQ-018 Arbitration: with PRI0=1, cyc_i[0] wins; otherwise the winner is the first requesting index scanning upward from last_owner+1, with wrap.
REQ-019 IDLE: on an edge with any cyc_i set, grant_o loads the one-hot winner, last_owner loads its index, and the state becomes BUSY.
REQ-020 BUSY: mcyc_o, mstb_o, mwe_o, msel_o, madr_o and mdat_o are combinational copies of the owner's inputs.
REQ-021 In IDLE and FLUSH, all master outputs SHALL be 0.
REQ-022 ack_o[owner] = mack_i & mstb_o combinationally; every other ack_o bit is 0; dat_o = mdat_i always.
REQ-023 Request-to-mcyc_o latency SHALL be 1 clock.
REQ-024 An owner keeps the grant across multiple strobes for as long as its cyc_i stays high.
REQ-025 Release: on an edge in BUSY where cyc_i[owner]=0, arbitration runs that same edge: a new grant is made with no idle cycle, or the state goes to IDLE when nothing is requesting.
REQ-026 Timeout counter: 8 bits; cleared in IDLE, on mack_i, and when mstb_o=0; increments each BUSY cycle with mstb_o=1 and mack_i=0.
REQ-027 When the counter reaches TIMEOUT-1 with mack_i=0, the next edge pulses err_o[owner] for exactly 1 cycle and enters FLUSH.
REQ-028 FLUSH holds the grant; on the edge where cyc_i[owner]=0, the state goes to IDLE and grant_o clears.
REQ-029 If mack_i arrives in the same cycle the timeout would fire, the ack wins: no err_o and no FLUSH.
REQ-030 A requester dropping cyc_i while it is not the owner has no effect; non-owner stb_i is ignored.
REQ-031 last_owner SHALL update only when a grant is issued.

Reset
REQ-032 While rst_i=0 at an edge: the state is IDLE, grant_o=0, last_owner=NREQ-1, the counter is 0, and err_o=0.
REQ-033 Consequently all master outputs and ack_o are 0 during reset.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer with no err_o pulse.
REQ-035 The first grant after reset SHALL go to the lowest requesting index.

Verification
REQ-036 Single request: cyc/stb[1]=1 with adr 0x1000 -> at the next edge grant_o=3'b010 and madr_o=0x1000; mack_i=1 -> ack_o=3'b010 in the same cycle.
REQ-037 Round-robin, PRI0=0: requesters 1 and 2 held continuously, each dropping cyc_i for 1 cycle after its ack -> grants alternate 1,2,1,2 with no idle cycle between them.
REQ-038 Priority, PRI0=1: requester 2 owns the bus and requester 0 requests -> 0 is granted on the edge after 2 drops cyc_i, ahead of a pending requester 1.
REQ-039 Timeout, TIMEOUT=4: stb held and mack_i never asserted -> err_o pulses 1 cycle at the 4th stalled cycle, mcyc_o=0 thereafter, and IDLE once the owner drops cyc_i.
REQ-040 Ack/timeout coincidence: mack_i=1 exactly on the cycle the count reaches 3 (TIMEOUT=4) -> ack_o asserted, err_o=0, and the state stays BUSY.
REQ-041 Reset mid-transfer: rst_i=0 for 1 edge during BUSY -> grant_o=0 and mcyc_o=0 in the next cycle, err_o never asserted.
